// File: rtl/i2s_tx.sv
// Playback-side I2S serializer: prefetches stereo frames from the DAC FIFO and
// shifts them MSB-first onto dacdat, framed by the codec-mastered daclrc.
module i2s_tx #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned UNDERRUN_MODE = 0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic                  tx_en,
    input  logic                  daclrc,
    output logic                  dacdat,
    input  logic                  dacfifo_empty,
    output logic                  dacfifo_read,
    input  logic [DATA_WIDTH-1:0] dacfifo_readdata,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  underrun_count
);

    localparam int unsigned HALF = DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_CAP  = 2'd2
    } fetch_state_t;

    fetch_state_t          r_state;
    logic                  r_lrc0;
    logic                  r_lrc1;
    logic [HALF-1:0]       r_shreg;
    logic [DATA_WIDTH-1:0] r_frame;
    logic [DATA_WIDTH-1:0] r_next_word;
    logic                  r_next_valid;
    logic [DATA_WIDTH-1:0] r_last_frame;
    logic                  r_started;
    logic                  r_dacdat;
    logic                  r_read;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_underrun_count;

    logic                  w_lrc_fall;
    logic                  w_lrc_rise;
    logic [DATA_WIDTH-1:0] w_new_frame;

    assign w_lrc_fall = r_lrc1 & ~r_lrc0;
    assign w_lrc_rise = ~r_lrc1 & r_lrc0;

    // Frame that a left-slot start would load
    always_comb begin
        w_new_frame = '0;
        if (tx_en) begin
            if (r_next_valid) begin
                w_new_frame = r_next_word;
            end else if (UNDERRUN_MODE != 0) begin
                w_new_frame = r_last_frame;
            end
        end
    end

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= F_IDLE;
            r_lrc0           <= 1'b0;
            r_lrc1           <= 1'b0;
            r_shreg          <= '0;
            r_frame          <= '0;
            r_next_word      <= '0;
            r_next_valid     <= 1'b0;
            r_last_frame     <= '0;
            r_started        <= 1'b0;
            r_read           <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_lrc0     <= daclrc;
            r_lrc1     <= r_lrc0;
            r_read     <= 1'b0;
            r_underrun <= 1'b0;

            // Only new reads are gated by tx_en; an issued read always lands
            case (r_state)
                F_IDLE: begin
                    if (tx_en && !r_next_valid && !dacfifo_empty) begin
                        r_read  <= 1'b1;
                        r_state <= F_WAIT;
                    end
                end
                F_WAIT: r_state <= F_CAP;
                F_CAP: begin
                    r_next_word  <= dacfifo_readdata;
                    r_next_valid <= 1'b1;
                    r_state      <= F_IDLE;
                end
                default: r_state <= F_IDLE;
            endcase

            // A left start sees the pre-capture next_valid, so a same-cycle capture is kept for the next frame
            if (w_lrc_fall) begin
                r_frame <= w_new_frame;
                r_shreg <= w_new_frame[DATA_WIDTH-1:HALF];
                if (tx_en) begin
                    r_started <= 1'b1;
                    if (r_next_valid) begin
                        r_last_frame <= r_next_word;
                        r_next_valid <= 1'b0;
                    end else begin
                        r_underrun <= 1'b1;
                        if (r_underrun_count != '1) begin
                            r_underrun_count <= r_underrun_count + CNT_WIDTH'(1);
                        end
                    end
                end
            end else if (w_lrc_rise) begin
                r_shreg <= (r_started && tx_en) ? r_frame[HALF-1:0] : '0;
            end else begin
                r_shreg <= {r_shreg[HALF-2:0], 1'b0};
            end
        end
    end

    // Launch on the falling edge so the codec sees stable data on its rising-edge sample
    always_ff @(negedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dacdat <= 1'b0;
        end else begin
            r_dacdat <= r_shreg[HALF-1];
        end
    end

    assign dacdat         = r_dacdat;
    assign dacfifo_read   = r_read;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule
